// File: rtl/instruction_issue_queue_if.sv
// Fetch-to-decode issue-queue bundle: fetch pushes instruction pairs, decode
// consumes them. The queue uses the slave modport; its environment uses master.
interface instruction_issue_queue_if #(
  parameter int bitsize = 11,
  parameter int DEPTH   = 4
);
  logic [31:0]              fetch_output1;
  logic [31:0]              fetch_output2;
  logic [bitsize-1:0]       fetch_pc;
  logic                     fetch_valid;
  logic                     IF_flush;
  logic                     PC_enable;
  logic [31:0]              issue_inst1;
  logic [31:0]              issue_inst2;
  logic [bitsize-1:0]       issue_pc;
  logic                     issue_valid1;
  logic                     issue_valid2;
  logic                     issue_ready;
  logic                     split_req;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output fetch_output1, fetch_output2, fetch_pc, fetch_valid, IF_flush,
           issue_ready, split_req,
    input  PC_enable, issue_inst1, issue_inst2, issue_pc, issue_valid1,
           issue_valid2, occupancy
  );

  modport slave (
    input  fetch_output1, fetch_output2, fetch_pc, fetch_valid, IF_flush,
           issue_ready, split_req,
    output PC_enable, issue_inst1, issue_inst2, issue_pc, issue_valid1,
           issue_valid2, occupancy
  );
endinterface

// File: rtl/instruction_issue_queue.sv
// Instruction-pair FIFO between fetch and decode, with optional split issue
// of a pair over two cycles and flush on branch redirect.
module instruction_issue_queue #(
  parameter int bitsize = 11,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {PAIR, SECOND} state_t;

  logic [31:0]        r_inst1 [DEPTH];
  logic [31:0]        r_inst2 [DEPTH];
  logic [bitsize-1:0] r_pc    [DEPTH];
  logic               r_v1    [DEPTH];
  logic               r_v2    [DEPTH];

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  state_t        r_state;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_hv1;
  logic w_hv2;
  logic w_split;
  logic w_toSecond;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_hv1   = r_v1[r_rdPtr];
  assign w_hv2   = r_v2[r_rdPtr];
  assign w_split = bus.split_req && w_hv1 && w_hv2;

  assign bus.PC_enable = !w_full && !bus.IF_flush;
  assign bus.occupancy = r_count;

  // An all-bubble pair carries nothing to issue, so it never takes a slot.
  assign w_push = bus.fetch_valid && bus.PC_enable &&
                  ((bus.fetch_output1 != 32'h0) || (bus.fetch_output2 != 32'h0));

  assign w_pop      = !w_empty && bus.issue_ready && ((r_state == SECOND) || !w_split);
  assign w_toSecond = !w_empty && bus.issue_ready && (r_state == PAIR) && w_split;

  always_comb begin
    bus.issue_inst1  = 32'h0;
    bus.issue_inst2  = 32'h0;
    bus.issue_pc     = '0;
    bus.issue_valid1 = 1'b0;
    bus.issue_valid2 = 1'b0;
    if (!w_empty) begin
      bus.issue_inst1 = r_inst1[r_rdPtr];
      bus.issue_inst2 = r_inst2[r_rdPtr];
      if (r_state == SECOND) begin
        bus.issue_pc     = r_pc[r_rdPtr] + bitsize'(4);
        bus.issue_valid2 = 1'b1;
      end else begin
        bus.issue_pc     = r_pc[r_rdPtr];
        bus.issue_valid1 = w_hv1;
        bus.issue_valid2 = w_hv2 && !w_split;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst1[r_wrPtr] <= bus.fetch_output1;
      r_inst2[r_wrPtr] <= bus.fetch_output2;
      r_pc[r_wrPtr]    <= bus.fetch_pc;
      r_v1[r_wrPtr]    <= (bus.fetch_output1 != 32'h0);
      r_v2[r_wrPtr]    <= (bus.fetch_output2 != 32'h0);
    end
  end

  // Flush wins over everything, including a pop decode sees in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_state <= PAIR;
    end else if (bus.IF_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_state <= PAIR;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        PAIR:    if (w_toSecond) r_state <= SECOND;
        SECOND:  if (w_pop)      r_state <= PAIR;
        default: r_state <= PAIR;
      endcase
    end
  end
endmodule
